conv_line_buffer: RTL and testbench
===================================

// Module: conv_line_buffer
// PURPOSE
// - Input-row staging stage of the APB convolution accelerator; sits between the APB data register and the 5x5 conv datapath.
// - Accepts packed 32-bit pixel words, unpacks them into a circular buffer of 5 rows x 28 pixels x 3 bits, and serves 5-pixel window columns to the conv engine.
// - Tracks row completion and buffer occupancy so software can stream rows 5..27 while earlier rows are being consumed.
// PARAMETERS
// - PIX_W        3   bits per pixel
// - ROW_LEN      28  pixels per row
// - PIX_PER_WORD 10  pixels carried per write word
// - NUM_ROWS     5   rows held (filter height)
// PORTS
// - HCLK         in   1   clock
// - HRESET       in   1   synchronous active-high reset
// - clear        in   1   sync flush for a new channel; same effect as HRESET
// - wr_valid     in   1   write word present
// - wr_data      in   32  packed pixels: pixel k of word at [29-3k -: 3]; bits 31:30 ignored
// - wr_ready     out  1   buffer can accept a word
// - row_done     out  1   one-cycle pulse: a full row was just committed
// - occ          out  3   committed rows held, 0..NUM_ROWS
// - window_valid out  1   occ == NUM_ROWS
// - row_consume  in   1   engine releases the oldest row
// - consume_err  out  1   sticky: row_consume seen while occ == 0
// - rd_en        in   1   column read request
// - rd_col       in   5   column index, 0..27
// - rd_data      out  15  rows oldest..newest: [3k+2:3k] = row (rd_base+k) mod 5
// - rd_valid     out  1   rd_data valid
// BEHAVIOUR
// - Reset and clear: wr_row=rd_base=word_cnt=occ=0, row_done=0, rd_valid=0, rd_data=0, consume_err=0, state=FILL. Pixel storage is not cleared.
// - Words per row = ceil(ROW_LEN/PIX_PER_WORD) = 3.
//   - Word 0 carries pixels 0-9, word 1 carries 10-19, word 2 carries 20-27.
//   - Word 2 bits [5:0] are ignored.
// - A write is accepted when wr_valid && wr_ready. The decoded pixels are written to row wr_row, and word_cnt increments.
// - On the accepted word with word_cnt==2:
//   - word_cnt goes to 0 and wr_row advances (mod 5); occ increments.
//   - row_done pulses in the next cycle.
//   - The row becomes readable in the cycle after acceptance.
// - FSM:
//   - FILL: occ<5 and wr_ready=1. Go to FULL when occ reaches 5.
//   - FULL: wr_ready=0 and window_valid=1. Go back to FILL when row_consume arrives.
//   - A write arriving in FULL is not accepted, and word_cnt is held.
// - Partial row: a consume in FILL never frees a row that is still being written. Only committed rows count toward occ.
// - row_consume with occ>0: rd_base advances (mod 5) and occ decrements.
// - Simultaneous commit and consume in the same cycle: occ is unchanged and both pointers advance.
// - Because FULL forces wr_ready=0, a commit and a consume in the same cycle only happen in FILL.
// - row_consume with occ==0 is ignored, and consume_err sets and stays set until HRESET or clear.
// - Read path, 1-cycle latency:
//   - rd_en in cycle t gives rd_data and rd_valid=1 in cycle t+1.
//   - rd_valid=0 when rd_en=0. rd_data holds its last value.
//   - rd_col>=28 returns zeros with rd_valid=1.
//   - Rows not yet committed (k >= occ) return whatever is stored; the engine reads only when window_valid=1.
// - Read during consume: the read uses the rd_base value sampled in the same cycle as rd_en, i.e. the pre-consume base.
// - clear or HRESET mid-row discards the partial row; the next word is treated as word 0.
// STRUCTURE
// - conv_pkg (shared):
//   - PIX_W, ROW_LEN, PIX_PER_WORD, NUM_ROWS, WORDS_PER_ROW
//   - typedef pix_t, typedef row_t (pix_t [ROW_LEN])
//   - function unpack_word(word, idx) returning pix_t[PIX_PER_WORD] plus a pixel-count field
// - Sub-module conv_word_unpack: combinational word->pixel demux with per-pixel write enables for a given word_cnt. Storage, pointers and the FSM stay in conv_line_buffer.
// TESTING
// 1. Reset, then 3 words for row 0 (pixel values 0..7 cycling) -> row_done pulses one cycle after word 2; occ=1; rd_col=27 returns pixel 27 = 3 in bits [2:0] on the next cycle.
// 2. Write 5 rows -> occ=5, window_valid=1, wr_ready=0. Extra word held with wr_valid=1 -> not accepted until row_consume; after the consume, wr_ready=1 and the word lands as word 0 of row slot 0.
// 3. With occ=3, the last word of a row and row_consume in the same cycle -> occ stays 3, rd_base=1, row_done pulses.
// 4. row_consume at occ=0 -> occ stays 0, consume_err=1 and stays set through further writes; clear drops it to 0.
// 5. Write 2 words of a row, then clear -> word_cnt=0, occ=0; the next 3 words form a complete row 0 with correct pixels and no stray data.
// 6. Fill rows holding constant values 1..5, consume twice, write rows 6 and 7 -> rd_col=0 returns {7,6,5,4,3} from bits [14:12] down to [2:0], showing wrap-around ordering.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared parameters, types and word-decode helpers for the conv line buffer.
package conv_pkg;

    localparam int PIX_W         = 3;
    localparam int ROW_LEN       = 28;
    localparam int PIX_PER_WORD  = 10;
    localparam int NUM_ROWS      = 5;
    localparam int WORDS_PER_ROW = (ROW_LEN + PIX_PER_WORD - 1) / PIX_PER_WORD;

    localparam int WORD_W    = 32;
    localparam int COL_W     = 5;   // column index 0..31
    localparam int ROW_IDX_W = 3;   // row slot index 0..NUM_ROWS-1
    localparam int OCC_W     = 3;   // occupancy 0..NUM_ROWS
    localparam int WCNT_W    = 2;   // word index within a row
    localparam int CNT_W     = 4;   // pixel count carried by one word

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t row_t [ROW_LEN];

    typedef struct packed {
        pix_t [PIX_PER_WORD-1:0] pix;
        logic [CNT_W-1:0]        count;   // pixels of this word that land inside the row
    } unpacked_word_t;

    typedef enum logic {
        ST_FILL,
        ST_FULL
    } state_e;

    // Pixel k sits at the top of the word and moves down PIX_W bits per pixel.
    function automatic unpacked_word_t unpack_word(input logic [WORD_W-1:0] word,
                                                   input logic [WCNT_W-1:0] idx);
        unpacked_word_t res;
        int remaining;
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            res.pix[k] = word[PIX_PER_WORD*PIX_W - 1 - PIX_W*k -: PIX_W];
        end
        remaining = ROW_LEN - int'(idx) * PIX_PER_WORD;
        if (remaining < 0) begin
            remaining = 0;
        end else if (remaining > PIX_PER_WORD) begin
            remaining = PIX_PER_WORD;
        end
        res.count = CNT_W'(remaining);
        return res;
    endfunction

    // Circular row-slot arithmetic; step never exceeds NUM_ROWS-1.
    function automatic logic [ROW_IDX_W-1:0] row_add(input logic [ROW_IDX_W-1:0] base,
                                                     input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_ROWS) begin
            sum = sum - NUM_ROWS;
        end
        return ROW_IDX_W'(sum);
    endfunction

endpackage

// File: rtl/conv_word_unpack.sv
// Combinational demux of one packed write word into pixels plus per-pixel write enables.
module conv_word_unpack
    import conv_pkg::*;
(
    input  logic [WORD_W-1:0]        word_i,
    input  logic [WCNT_W-1:0]        word_cnt_i,
    output pix_t [PIX_PER_WORD-1:0]  pix_o,
    output logic [PIX_PER_WORD-1:0]  we_o,
    output logic [COL_W-1:0]         col_base_o
);

    unpacked_word_t unpacked;
    logic           unused_top_bits;

    // The two spare bits above the pixel field carry nothing.
    assign unused_top_bits = ^word_i[WORD_W-1:PIX_PER_WORD*PIX_W];

    // Decode the word and enable only the pixels that fall inside the row.
    always_comb begin
        unpacked   = unpack_word(word_i, word_cnt_i);
        pix_o      = unpacked.pix;
        col_base_o = COL_W'(int'(word_cnt_i) * PIX_PER_WORD);
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            we_o[k] = (k < int'(unpacked.count));
        end
    end

endmodule

// File: rtl/conv_line_buffer.sv
// Five-row circular line buffer: unpacks pixel words into rows and serves window columns.
module conv_line_buffer
    import conv_pkg::*;
(
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      clear,
    input  logic                      wr_valid,
    input  logic [WORD_W-1:0]         wr_data,
    output logic                      wr_ready,
    output logic                      row_done,
    output logic [OCC_W-1:0]          occ,
    output logic                      window_valid,
    input  logic                      row_consume,
    output logic                      consume_err,
    input  logic                      rd_en,
    input  logic [COL_W-1:0]          rd_col,
    output logic [NUM_ROWS*PIX_W-1:0] rd_data,
    output logic                      rd_valid
);

    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(NUM_ROWS);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_ROW - 1);
    localparam logic [COL_W-1:0]  COL_LIMIT = COL_W'(ROW_LEN);

    row_t                      mem_q [NUM_ROWS];

    state_e                    state_q, state_d;
    logic [ROW_IDX_W-1:0]      wr_row_q, wr_row_d;
    logic [ROW_IDX_W-1:0]      rd_base_q, rd_base_d;
    logic [WCNT_W-1:0]         word_cnt_q, word_cnt_d;
    logic [OCC_W-1:0]          occ_q, occ_d;
    logic                      row_done_q;
    logic                      consume_err_q, consume_err_d;
    logic                      rd_valid_q;
    logic [NUM_ROWS*PIX_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_ROWS*PIX_W-1:0] rd_word;

    pix_t [PIX_PER_WORD-1:0]   word_pix;
    logic [PIX_PER_WORD-1:0]   word_we;
    logic [COL_W-1:0]          col_base;

    logic                      wr_accept;
    logic                      commit;
    logic                      consume_ok;

    conv_word_unpack u_unpack (
        .word_i     (wr_data),
        .word_cnt_i (word_cnt_q),
        .pix_o      (word_pix),
        .we_o       (word_we),
        .col_base_o (col_base)
    );

    assign wr_ready     = (state_q == ST_FILL);
    assign window_valid = (state_q == ST_FULL);
    assign wr_accept    = wr_valid && wr_ready;
    assign commit       = wr_accept && (word_cnt_q == LAST_WORD);
    // Only committed rows are in occ, so a consume can never free the row being written.
    assign consume_ok   = row_consume && (occ_q != '0);

    assign row_done    = row_done_q;
    assign occ         = occ_q;
    assign consume_err = consume_err_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

    // Pixel storage: accepted word lands in the current write row.
    // NOTE: storage has no reset; validity is tracked by pointers and occ alone, so the array can map to RAM.
    always_ff @(posedge HCLK) begin
        if (wr_accept) begin
            for (int k = 0; k < PIX_PER_WORD; k++) begin
                if (word_we[k]) begin
                    mem_q[wr_row_q][col_base + COL_W'(k)] <= word_pix[k];
                end
            end
        end
    end

    // Gather one column, oldest committed row in the low bits; out-of-range columns read zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rd_word = '0;
        if (rd_col < COL_LIMIT) begin
            for (int k = 0; k < NUM_ROWS; k++) begin
                rd_word[PIX_W*k +: PIX_W] = mem_q[row_add(rd_base_q, k)][rd_col];
            end
        end
    end

    // Next-state for pointers, occupancy, sticky error and the read register.
    always_comb begin
        wr_row_d      = wr_row_q;
        rd_base_d     = rd_base_q;
        word_cnt_d    = word_cnt_q;
        occ_d         = occ_q;
        consume_err_d = consume_err_q;
        rd_data_d     = rd_data_q;

        if (commit) begin
            word_cnt_d = '0;
            wr_row_d   = row_add(wr_row_q, 1);
        end else if (wr_accept) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end

        if (consume_ok) begin
            rd_base_d = row_add(rd_base_q, 1);
        end else if (row_consume) begin
            consume_err_d = 1'b1;
        end

        // A commit and a consume together leave occ unchanged.
        case ({commit, consume_ok})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (rd_en) begin
            rd_data_d = rd_word;
        end
    end

    // FSM next-state: FULL blocks writes until the engine releases a row.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (occ_d == OCC_FULL) state_d = ST_FULL;
            ST_FULL: if (row_consume)       state_d = ST_FILL;
            default:                        state_d = ST_FILL;
        endcase
    end

    // Control registers; clear flushes exactly like reset.
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (HRESET || clear) begin
            state_q       <= ST_FILL;
            wr_row_q      <= '0;
            rd_base_q     <= '0;
            word_cnt_q    <= '0;
            occ_q         <= '0;
            row_done_q    <= 1'b0;
            consume_err_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_row_q      <= wr_row_d;
            rd_base_q     <= rd_base_d;
            word_cnt_q    <= word_cnt_d;
            occ_q         <= occ_d;
            row_done_q    <= commit;
            consume_err_q <= consume_err_d;
            rd_valid_q    <= rd_en;
            rd_data_q     <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed self-checking bench for conv_line_buffer.
module tb_conv_line_buffer;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        clear = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        row_done;
    logic [2:0]  occ;
    logic        window_valid;
    logic        row_consume = 1'b0;
    logic        consume_err;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_col = '0;
    logic [14:0] rd_data;
    logic        rd_valid;

    int total = 0;
    int bad = 0;

    conv_line_buffer dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .clear        (clear),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .row_done     (row_done),
        .occ          (occ),
        .window_valid (window_valid),
        .row_consume  (row_consume),
        .consume_err  (consume_err),
        .rd_en        (rd_en),
        .rd_col       (rd_col),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Word w of a row; cval < 0 gives pixel p = p % 8, otherwise every pixel = cval.
    function automatic logic [31:0] mk_word(input int w, input int cval);
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < 10; k++) begin
            if (w * 10 + k < 28) begin
                d[29 - 3*k -: 3] = (cval < 0) ? 3'((w * 10 + k) % 8) : 3'(cval);
            end
        end
        return d;
    endfunction

    // Column image with r0 (oldest) in bits [2:0] and r4 (newest) in bits [14:12].
    function automatic logic [31:0] col5(input int r0, input int r1, input int r2,
                                         input int r3, input int r4);
        return {17'd0, 3'(r4), 3'(r3), 3'(r2), 3'(r1), 3'(r0)};
    endfunction

    task automatic write_word(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic write_row(input int cval);
        for (int w = 0; w < 3; w++) write_word(mk_word(w, cval));
    endtask

    task automatic consume();
        row_consume = 1'b1;
        tick();
        row_consume = 1'b0;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    task automatic read_check(input string tag, input int col, input logic [31:0] mask,
                              input logic [31:0] exp);
        rd_en  = 1'b1;
        rd_col = 5'(col);
        tick();
        rd_en  = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check(tag, {17'd0, rd_data} & mask, exp);
    endtask

    initial begin
        // 1: reset state, single row, read latency and out-of-range column
        do_reset();
        check("rst_occ", {29'd0, occ}, 0);
        check("rst_wr_ready", {31'd0, wr_ready}, 1);
        check("rst_row_done", {31'd0, row_done}, 0);
        check("rst_rd_valid", {31'd0, rd_valid}, 0);
        check("rst_rd_data", {17'd0, rd_data}, 0);
        check("rst_err", {31'd0, consume_err}, 0);
        check("rst_window", {31'd0, window_valid}, 0);
        write_word(mk_word(0, -1));
        write_word(mk_word(1, -1));
        check("t1_no_done_early", {31'd0, row_done}, 0);
        write_word(mk_word(2, -1));
        check("t1_row_done", {31'd0, row_done}, 1);
        check("t1_occ", {29'd0, occ}, 1);
        tick();
        check("t1_row_done_pulse", {31'd0, row_done}, 0);
        read_check("t1_col27", 27, 32'h7, 3);
        read_check("t1_col12", 12, 32'h7, 4);
        read_check("t1_col28", 28, 32'h7fff, 0);
        tick();
        check("t1_rd_valid_idle", {31'd0, rd_valid}, 0);
        check("t1_rd_data_hold", {17'd0, rd_data}, 0);

        // 2: fill to FULL, held word waits for a consume, then lands as word 0 of slot 0
        for (int r = 1; r <= 4; r++) write_row(r);
        check("t2_occ_full", {29'd0, occ}, 5);
        check("t2_window", {31'd0, window_valid}, 1);
        check("t2_wr_ready", {31'd0, wr_ready}, 0);
        wr_valid = 1'b1;
        wr_data  = mk_word(0, 6);
        tick();
        tick();
        check("t2_held_occ", {29'd0, occ}, 5);
        check("t2_held_ready", {31'd0, wr_ready}, 0);
        row_consume = 1'b1;
        tick();
        row_consume = 1'b0;
        check("t2_after_consume_occ", {29'd0, occ}, 4);
        check("t2_after_consume_ready", {31'd0, wr_ready}, 1);
        tick();
        wr_valid = 1'b0;
        check("t2_word0_no_commit", {29'd0, occ}, 4);
        write_word(mk_word(1, 7));
        write_word(mk_word(2, 7));
        check("t2_recommit_done", {31'd0, row_done}, 1);
        check("t2_refull", {29'd0, occ}, 5);
        read_check("t2_col0", 0, 32'h7fff, col5(1, 2, 3, 4, 6));
        read_check("t2_col15", 15, 32'h7fff, col5(1, 2, 3, 4, 7));

        // 3: commit and consume in the same cycle at occ=3
        do_reset();
        write_row(1);
        write_row(2);
        write_row(3);
        write_word(mk_word(0, 5));
        write_word(mk_word(1, 5));
        wr_valid    = 1'b1;
        wr_data     = mk_word(2, 5);
        row_consume = 1'b1;
        tick();
        wr_valid    = 1'b0;
        row_consume = 1'b0;
        check("t3_occ", {29'd0, occ}, 3);
        check("t3_row_done", {31'd0, row_done}, 1);
        read_check("t3_col0_base1", 0, 32'h1ff, col5(2, 3, 5, 0, 0));

        // 4: consume at occ=0 sets a sticky error; clear drops it
        do_reset();
        consume();
        check("t4_occ", {29'd0, occ}, 0);
        check("t4_err", {31'd0, consume_err}, 1);
        write_row(1);
        check("t4_err_sticky", {31'd0, consume_err}, 1);
        check("t4_occ_after_write", {29'd0, occ}, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_err_cleared", {31'd0, consume_err}, 0);
        check("t4_occ_cleared", {29'd0, occ}, 0);

        // 5: clear mid-row discards the partial row
        write_word(mk_word(0, 7));
        write_word(mk_word(1, 7));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_occ_cleared", {29'd0, occ}, 0);
        write_word(mk_word(0, -1));
        check("t5_word0_no_commit", {29'd0, occ}, 0);
        check("t5_word0_no_done", {31'd0, row_done}, 0);
        write_word(mk_word(1, -1));
        write_word(mk_word(2, -1));
        check("t5_row_done", {31'd0, row_done}, 1);
        check("t5_occ", {29'd0, occ}, 1);
        read_check("t5_col0", 0, 32'h7, 0);
        read_check("t5_col9", 9, 32'h7, 1);
        read_check("t5_col10", 10, 32'h7, 2);
        read_check("t5_col20", 20, 32'h7, 4);
        read_check("t5_col27", 27, 32'h7, 3);

        // 6: wrap-around ordering and read during consume
        do_reset();
        for (int r = 1; r <= 5; r++) write_row(r);
        check("t6_occ_full", {29'd0, occ}, 5);
        check("t6_window", {31'd0, window_valid}, 1);
        consume();
        consume();
        check("t6_occ_after_consume", {29'd0, occ}, 3);
        write_row(6);
        write_row(7);
        check("t6_occ_refull", {29'd0, occ}, 5);
        read_check("t6_col0_wrap", 0, 32'h7fff, col5(3, 4, 5, 6, 7));
        rd_en       = 1'b1;
        rd_col      = 5'd27;
        row_consume = 1'b1;
        tick();
        rd_en       = 1'b0;
        row_consume = 1'b0;
        check("t6_read_pre_consume", {17'd0, rd_data}, col5(3, 4, 5, 6, 7));
        check("t6_occ_consumed", {29'd0, occ}, 4);
        read_check("t6_col0_base3", 0, 32'h7fff, col5(4, 5, 6, 7, 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
